// File: rtl/rs_ls_queue.sv
// rs_ls_queue: program-ordered load/store reservation queue with broadcast wakeup and in-order issue.
// Optional performance counters are enabled by defining RS_LS_QUEUE_PERF_EN.
module rs_ls_queue #(
    parameter int DEPTH  = 4,
    parameter int NCH    = 3,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     flush,
    input  logic                     alloc_en,
    input  logic [OP_W-1:0]          alloc_op,
    input  logic [DATA_W-1:0]        alloc_imm,
    input  logic [TAG_W-1:0]         alloc_tagx,
    input  logic [TAG_W-1:0]         alloc_tagy,
    input  logic [DATA_W-1:0]        alloc_datax,
    input  logic [DATA_W-1:0]        alloc_datay,
    input  logic [TAG_W-1:0]         alloc_tagw,
    input  logic [ADDR_W-1:0]        alloc_addrw,
    input  logic [NCH-1:0]           cdb_en,
    input  logic [NCH*TAG_W-1:0]     cdb_tag,
    input  logic [NCH*DATA_W-1:0]    cdb_data,
    output logic                     full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output logic [OP_W-1:0]          issue_op,
    output logic [DATA_W-1:0]        issue_offset,
    output logic [DATA_W-1:0]        issue_datax,
    output logic [DATA_W-1:0]        issue_datay,
    output logic [TAG_W-1:0]         issue_tagw,
`ifdef RS_LS_QUEUE_PERF_EN
    output logic [31:0]              perf_issue_cnt,
    output logic [31:0]              perf_full_stall_cnt,
    output logic [31:0]              perf_wait_cnt,
`endif
    output logic [ADDR_W-1:0]        issue_target
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PW-1:0]     head, tail;
    logic              valid_q [DEPTH];
    logic [OP_W-1:0]   op_q    [DEPTH];
    logic [DATA_W-1:0] imm_q   [DEPTH];
    logic [TAG_W-1:0]  tagx_q  [DEPTH];
    logic [TAG_W-1:0]  tagy_q  [DEPTH];
    logic [DATA_W-1:0] datax_q [DEPTH];
    logic [DATA_W-1:0] datay_q [DEPTH];
    logic [TAG_W-1:0]  tagw_q  [DEPTH];
    logic [ADDR_W-1:0] addrw_q [DEPTH];
    logic [TAG_W-1:0]  wtagx [DEPTH], wtagy [DEPTH];
    logic [DATA_W-1:0] wdatax [DEPTH], wdatay [DEPTH];
    logic [TAG_W-1:0]  atagx, atagy;
    logic [DATA_W-1:0] adatax, adatay;
    logic              fire, do_alloc;

    // Scan channels high to low so the lowest matching channel has the final say.
    function automatic logic [TAG_W+DATA_W-1:0] wake(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        logic [TAG_W+DATA_W-1:0] r;
        r = {t, d};
        for (int c = NCH-1; c >= 0; c--)
            if (t != '0 && cdb_en[c] && cdb_tag[c*TAG_W +: TAG_W] == t)
                r = {TAG_W'(0), cdb_data[c*DATA_W +: DATA_W]};
        return r;
    endfunction

    assign full         = count == CW'(DEPTH);
    assign issue_valid  = rdy && valid_q[head] && tagx_q[head] == '0 && tagy_q[head] == '0;
    assign fire         = issue_valid && issue_ready;
    assign do_alloc     = alloc_en && !full;
    assign issue_op     = op_q[head];
    assign issue_offset = imm_q[head];
    assign issue_datax  = datax_q[head];
    assign issue_datay  = datay_q[head];
    assign issue_tagw   = tagw_q[head];
    assign issue_target = addrw_q[head];

    // Operand values after this cycle's broadcasts, for stored entries and the incoming op.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {wtagx[i], wdatax[i]} = wake(tagx_q[i], datax_q[i]);
            {wtagy[i], wdatay[i]} = wake(tagy_q[i], datay_q[i]);
        end
        {atagx, adatax} = wake(alloc_tagx, alloc_datax);
        {atagy, adatay} = wake(alloc_tagy, alloc_datay);
    end

    // Queue state: clear on reset/flush, otherwise wakeup, retire head and append at tail.
    always_ff @(posedge clk) begin
        if (rst || (rdy && flush)) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                op_q[i]    <= '0;
                imm_q[i]   <= '0;
                tagx_q[i]  <= '0;
                tagy_q[i]  <= '0;
                datax_q[i] <= '0;
                datay_q[i] <= '0;
                tagw_q[i]  <= '0;
                addrw_q[i] <= '0;
            end
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
                tagx_q[i]  <= wtagx[i];
                tagy_q[i]  <= wtagy[i];
                datax_q[i] <= wdatax[i];
                datay_q[i] <= wdatay[i];
            end
            if (fire) begin
                valid_q[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (do_alloc) begin
                valid_q[tail] <= 1'b1;
                op_q[tail]    <= alloc_op;
                imm_q[tail]   <= alloc_imm;
                tagx_q[tail]  <= atagx;
                tagy_q[tail]  <= atagy;
                datax_q[tail] <= adatax;
                datay_q[tail] <= adatay;
                tagw_q[tail]  <= alloc_tagw;
                addrw_q[tail] <= alloc_addrw;
                tail          <= tail + PW'(1);
            end
            count <= count + CW'(do_alloc) - CW'(fire);
        end
    end

`ifdef RS_LS_QUEUE_PERF_EN
    // Event counters survive flush and freeze while the queue is stalled by rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt      <= '0;
            perf_full_stall_cnt <= '0;
            perf_wait_cnt       <= '0;
        end else if (rdy) begin
            perf_issue_cnt      <= perf_issue_cnt + 32'(fire);
            perf_full_stall_cnt <= perf_full_stall_cnt + 32'(alloc_en && full);
            perf_wait_cnt       <= perf_wait_cnt + 32'(valid_q[head] && !issue_valid);
        end
    end
`endif
endmodule

// File: tb/tb_rs_ls_queue.sv
// tb_rs_ls_queue: randomized and directed checks of rs_ls_queue against a queue-based reference model.
module tb_rs_ls_queue;
    localparam int DEPTH = 4;

    logic        clk = 0, rst, rdy, flush, alloc_en, issue_ready;
    logic [5:0]  alloc_op;
    logic [31:0] alloc_imm, alloc_datax, alloc_datay;
    logic [3:0]  alloc_tagx, alloc_tagy, alloc_tagw;
    logic [4:0]  alloc_addrw;
    logic [2:0]  cdb_en;
    logic [11:0] cdb_tag;
    logic [95:0] cdb_data;
    logic        full, issue_valid;
    logic [2:0]  count;
    logic [5:0]  issue_op;
    logic [31:0] issue_offset, issue_datax, issue_datay;
    logic [3:0]  issue_tagw;
    logic [4:0]  issue_target;
    int n_run = 0, n_fail = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] imm, dx, dy;
        logic [3:0]  tx, ty, tw;
        logic [4:0]  aw;
    } ent_t;
    ent_t q[$];

    rs_ls_queue dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .alloc_en(alloc_en),
        .alloc_op(alloc_op), .alloc_imm(alloc_imm), .alloc_tagx(alloc_tagx), .alloc_tagy(alloc_tagy),
        .alloc_datax(alloc_datax), .alloc_datay(alloc_datay), .alloc_tagw(alloc_tagw), .alloc_addrw(alloc_addrw),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .full(full), .count(count),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op), .issue_offset(issue_offset),
        .issue_datax(issue_datax), .issue_datay(issue_datay), .issue_tagw(issue_tagw), .issue_target(issue_target)
    );

    always #5 clk = ~clk;

    // First channel (lowest index) carrying a matching tag supplies the value.
    function automatic logic [35:0] wk(input logic [3:0] t, input logic [31:0] d);
        for (int i = 0; i < 3; i++)
            if (t != 0 && cdb_en[i] && cdb_tag[i*4 +: 4] == t) return {4'd0, cdb_data[i*32 +: 32]};
        return {t, d};
    endfunction

    function automatic logic exp_iv();
        return rdy && q.size() > 0 && q[0].tx == 0 && q[0].ty == 0;
    endfunction

    task automatic model_step();
        bit fire, al;
        ent_t e;
        if (rst) q.delete();
        else if (rdy) begin
            if (flush) q.delete();
            else begin
                fire = exp_iv() && issue_ready;
                al = alloc_en && q.size() < DEPTH;
                foreach (q[k]) begin
                    {q[k].tx, q[k].dx} = wk(q[k].tx, q[k].dx);
                    {q[k].ty, q[k].dy} = wk(q[k].ty, q[k].dy);
                end
                if (fire) void'(q.pop_front());
                if (al) begin
                    e.op = alloc_op; e.imm = alloc_imm; e.tw = alloc_tagw; e.aw = alloc_addrw;
                    {e.tx, e.dx} = wk(alloc_tagx, alloc_datax);
                    {e.ty, e.dy} = wk(alloc_tagy, alloc_datay);
                    q.push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; rdy = 1; flush = 0; alloc_en = 0; issue_ready = 0;
        alloc_op = 0; alloc_imm = 0; alloc_datax = 0; alloc_datay = 0;
        alloc_tagx = 0; alloc_tagy = 0; alloc_tagw = 0; alloc_addrw = 0;
        cdb_en = 0; cdb_tag = 0; cdb_data = 0;
    endtask

    task automatic set_alloc(input logic [5:0] op, input logic [3:0] tx, input logic [31:0] dx,
                             input logic [3:0] ty, input logic [31:0] dy);
        alloc_en = 1; alloc_op = op; alloc_imm = 32'h100 + 32'(op);
        alloc_tagx = tx; alloc_datax = dx; alloc_tagy = ty; alloc_datay = dy;
        alloc_tagw = op[3:0]; alloc_addrw = op[4:0] ^ 5'h15;
    endtask

    task automatic set_cdb(input int ch, input logic [3:0] t, input logic [31:0] d);
        cdb_en[ch] = 1; cdb_tag[ch*4 +: 4] = t; cdb_data[ch*32 +: 32] = d;
    endtask

    task automatic test_reset();
        idle(); rst = 1; tick(); rst = 0;
        n_run++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", count); end
        n_run++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%0b want=0", full); end
        n_run++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b want=0", issue_valid); end
        n_run++; if ({issue_op, issue_offset, issue_datax, issue_datay, issue_tagw, issue_target} !== '0) begin
            n_fail++; $display("FAIL reset_fields got op=%0h off=%0h dx=%0h want all 0", issue_op, issue_offset, issue_datax); end
    endtask

    task automatic test_fill();
        idle();
        for (int i = 1; i <= 4; i++) begin set_alloc(6'(i), 0, 32'(i*3), 0, 32'(i*5)); tick(); end
        n_run++; if (count !== 3'd4 || full !== 1'b1) begin n_fail++; $display("FAIL fill_full got count=%0d full=%0b want 4/1", count, full); end
        set_alloc(6'd9, 0, 0, 0, 0); tick();
        n_run++; if (count !== 3'd4 || issue_op !== 6'd1) begin n_fail++; $display("FAIL fill_ignored got count=%0d op=%0d want 4/1", count, issue_op); end
        idle(); issue_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_run++; if (issue_valid !== 1'b1 || issue_op !== 6'(i) || issue_datax !== 32'(i*3) || issue_datay !== 32'(i*5)) begin
                n_fail++; $display("FAIL fill_order got v=%0b op=%0d dx=%0h want 1/%0d/%0h", issue_valid, issue_op, issue_datax, i, i*3); end
            tick();
        end
        n_run++; if (count !== 3'd0 || issue_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drain got count=%0d v=%0b want 0/0", count, issue_valid); end
    endtask

    task automatic test_wakeup();
        idle(); set_alloc(6'd11, 4'd3, 0, 0, 32'h55); tick(); idle();
        n_run++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_locked got=%0b want=0", issue_valid); end
        tick();
        set_cdb(0, 4'd6, 32'hBAD); set_cdb(1, 4'd3, 32'h1000); cdb_en[0] = 0; tick(); idle();
        n_run++; if (issue_valid !== 1'b1 || issue_datax !== 32'h1000) begin
            n_fail++; $display("FAIL wake_capture got v=%0b dx=%0h want 1/1000", issue_valid, issue_datax); end
        issue_ready = 1; tick(); idle();
        set_alloc(6'd12, 4'd7, 0, 0, 0); set_cdb(2, 4'd7, 32'hB); tick(); idle();
        set_cdb(2, 4'd7, 32'hC2); set_cdb(0, 4'd7, 32'hA0); tick(); idle();
        n_run++; if (issue_valid !== 1'b1 || issue_datax !== 32'hB) begin
            n_fail++; $display("FAIL wake_bypass_x got v=%0b dx=%0h want 1/b", issue_valid, issue_datax); end
        issue_ready = 1; tick(); idle();
        set_alloc(6'd13, 4'd7, 0, 0, 0); tick(); idle();
        set_cdb(2, 4'd7, 32'hC2); set_cdb(0, 4'd7, 32'hA0); tick(); idle();
        n_run++; if (issue_datax !== 32'hA0) begin n_fail++; $display("FAIL wake_lowest got=%0h want=a0", issue_datax); end
        issue_ready = 1; tick(); idle();
    endtask

    task automatic test_bypass();
        idle(); set_alloc(6'd14, 0, 32'h7, 4'd5, 0); set_cdb(2, 4'd5, 32'hDEAD); tick(); idle();
        n_run++; if (issue_valid !== 1'b1 || issue_datay !== 32'hDEAD) begin
            n_fail++; $display("FAIL bypass got v=%0b dy=%0h want 1/dead", issue_valid, issue_datay); end
        issue_ready = 1; tick(); idle();
    endtask

    task automatic test_head_locked();
        idle(); set_alloc(6'd21, 4'd2, 0, 0, 0); tick(); set_alloc(6'd22, 0, 0, 0, 0); tick(); idle();
        issue_ready = 1;
        for (int i = 0; i < 2; i++) begin
            n_run++; if (issue_valid !== 1'b0 || count !== 3'd2) begin
                n_fail++; $display("FAIL head_block got v=%0b count=%0d want 0/2", issue_valid, count); end
            tick();
        end
        set_cdb(1, 4'd2, 32'h22); tick(); cdb_en = 0; #1;
        n_run++; if (issue_valid !== 1'b1 || issue_op !== 6'd21) begin
            n_fail++; $display("FAIL head_first got v=%0b op=%0d want 1/21", issue_valid, issue_op); end
        tick();
        n_run++; if (issue_valid !== 1'b1 || issue_op !== 6'd22) begin
            n_fail++; $display("FAIL head_second got v=%0b op=%0d want 1/22", issue_valid, issue_op); end
        tick(); idle();
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 3; i++) begin set_alloc(6'(30+i), 0, 0, 0, 0); tick(); end
        set_alloc(6'd33, 0, 0, 0, 0); flush = 1; issue_ready = 1; tick(); idle();
        n_run++; if (count !== 3'd0 || issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush got count=%0d v=%0b want 0/0", count, issue_valid); end
        tick();
        n_run++; if (count !== 3'd0 || issue_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_absent got count=%0d v=%0b want 0/0", count, issue_valid); end
    endtask

    task automatic test_back_to_back();
        int nxt = 40, aop = 41;
        idle(); set_alloc(6'd40, 0, 0, 0, 0); tick();
        for (int c = 0; c < 10; c++) begin
            set_alloc(6'(aop), 0, 0, 0, 0); issue_ready = 1; rdy = !(c == 4 || c == 5); #1;
            n_run++; if (count !== 3'd1 || issue_valid !== rdy || issue_op !== 6'(nxt)) begin
                n_fail++; $display("FAIL b2b cyc%0d got count=%0d v=%0b op=%0d want 1/%0b/%0d", c, count, issue_valid, issue_op, rdy, nxt); end
            if (rdy) begin nxt++; aop++; end
            tick();
        end
        idle(); issue_ready = 1; tick(); idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = $urandom_range(0, 149) == 0; rdy = $urandom_range(0, 9) != 0; flush = $urandom_range(0, 39) == 0;
            alloc_en = $urandom_range(0, 1); alloc_op = 6'($urandom); alloc_imm = $urandom;
            alloc_tagx = $urandom_range(0, 2) == 0 ? 4'($urandom_range(1, 7)) : 4'd0;
            alloc_tagy = $urandom_range(0, 2) == 0 ? 4'($urandom_range(1, 7)) : 4'd0;
            alloc_datax = $urandom; alloc_datay = $urandom; alloc_tagw = 4'($urandom); alloc_addrw = 5'($urandom);
            issue_ready = $urandom_range(0, 3) != 0; cdb_en = 3'($urandom);
            cdb_tag = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            cdb_data = {$urandom, $urandom, $urandom};
            tick();
            n_run++; if (issue_valid !== exp_iv() || count !== 3'(q.size()) || full !== (q.size() == DEPTH)) begin
                n_fail++; $display("FAIL rand cyc%0d got v=%0b count=%0d full=%0b want %0b/%0d", c, issue_valid, count, full, exp_iv(), q.size()); end
            if (q.size() > 0) begin
                n_run++; if ({issue_op, issue_offset, issue_datax, issue_datay, issue_tagw, issue_target} !==
                             {q[0].op, q[0].imm, q[0].dx, q[0].dy, q[0].tw, q[0].aw}) begin
                    n_fail++; $display("FAIL rand_fields cyc%0d got op=%0h dx=%0h dy=%0h want op=%0h dx=%0h dy=%0h",
                                       c, issue_op, issue_datax, issue_datay, q[0].op, q[0].dx, q[0].dy); end
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        idle(); set_alloc(6'd50, 0, 32'h9, 0, 0); tick(); set_alloc(6'd51, 4'd4, 0, 0, 0); tick();
        idle(); rst = 1; tick(); rst = 0; #1;
        n_run++; if (count !== 3'd0 || issue_valid !== 1'b0 || issue_op !== 6'd0 || issue_datax !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset got count=%0d v=%0b op=%0d dx=%0h want 0/0/0/0", count, issue_valid, issue_op, issue_datax); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wakeup();
        test_bypass();
        test_head_locked();
        test_flush();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
